// File: rtl/bist_pkg.sv
// Shared constants, state encoding and LFSR step for the BIST stimulus/compactor wrapper.
// The tap masks select the feedback bits of the 12-bit LFSR and the 8-bit MISR.
package bist_pkg;

   localparam int PI_W = 12;
   localparam int PO_W = 8;

   // Feedback taps: LFSR bits 11,5,3,0 and MISR bits 7,5,4,3
   localparam logic [PI_W-1:0] LFSR_TAPS = 12'h829;
   localparam logic [PO_W-1:0] MISR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_APPLY,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] v);
      return {v[PI_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_misr.sv
// 8-bit multiple-input signature register with synchronous clear and enable.
// o_next exposes the value the register takes on an enabled edge.
module bist_misr
   import bist_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clr,
   input  logic            i_en,
   input  logic [PO_W-1:0] i_data,
   output logic [PO_W-1:0] o_sig,
   output logic [PO_W-1:0] o_next
);

   logic [PO_W-1:0] r_sig;
   logic [PO_W-1:0] w_next;

   assign w_next = {r_sig[PO_W-2:0], ^(r_sig & MISR_TAPS)} ^ i_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (i_clr) begin
         r_sig <= '0;
      end else if (i_en) begin
         r_sig <= w_next;
      end
   end

   assign o_sig  = r_sig;
   assign o_next = w_next;

endmodule

// File: rtl/bist_stim_compactor.sv
// Self-test wrapper: LFSR drives the netlist inputs, MISR compacts its outputs,
// and the final signature is compared against golden_sig on entry to DONE.
module bist_stim_compactor
   import bist_pkg::*;
#(
   parameter int unsigned PAT_CNT    = 256,
   parameter int unsigned SETTLE_CYC = 1,
   parameter logic [11:0] SEED       = 12'h001
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [PO_W-1:0] golden_sig,
   input  logic [PO_W-1:0] po_in,
   output logic [PI_W-1:0] pi_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [PO_W-1:0] signature,
   output logic [11:0]     pat_idx
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1
   localparam logic [PI_W-1:0] SEED_EFF    = (SEED == 12'h000) ? 12'h001 : SEED;
   localparam logic [11:0]     PAT_LAST    = 12'(PAT_CNT);
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam state_t          ST_AFTER    = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_APPLY;

   state_t          r_state;
   logic [PI_W-1:0] r_lfsr;
   logic [11:0]     r_pat_idx;
   logic [3:0]      r_settle;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;

   logic [11:0]     w_pat_inc;
   logic            w_misr_clr;
   logic            w_misr_en;
   logic [PO_W-1:0] w_misr_sig;
   logic [PO_W-1:0] w_misr_next;

   assign w_pat_inc  = r_pat_idx + 12'd1;
   assign w_misr_clr = (r_state == ST_SEED) && !abort;
   assign w_misr_en  = (r_state == ST_CAPTURE) && !abort;

   bist_misr u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_misr_clr),
      .i_en   (w_misr_en),
      .i_data (po_in),
      .o_sig  (w_misr_sig),
      .o_next (w_misr_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_lfsr    <= '0;
         r_pat_idx <= '0;
         r_settle  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else if (abort) begin
         // Pattern state is kept for inspection; only control returns to idle
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_SEED;
                  r_busy  <= 1'b1;
               end
            end
            ST_SEED: begin
               r_lfsr    <= SEED_EFF;
               r_pat_idx <= '0;
               r_settle  <= '0;
               r_state   <= ST_AFTER;
            end
            ST_APPLY: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= ST_CAPTURE;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            ST_CAPTURE: begin
               r_lfsr    <= lfsr_next(r_lfsr);
               r_pat_idx <= w_pat_inc;
               r_settle  <= '0;
               if (w_pat_inc == PAT_LAST) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_misr_next == golden_sig);
               end else begin
                  r_state <= ST_AFTER;
               end
            end
            ST_DONE: begin
               if (start) begin
                  r_state <= ST_SEED;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign pi_out    = r_lfsr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = w_misr_sig;
   assign pat_idx   = r_pat_idx;

endmodule

// File: tb/tb_bist_stim_compactor.sv
// Directed bench: instance A (2 patterns, no settle) runs a table of constant responses,
// instance B (4095 patterns, 1 settle) covers LFSR order, abort, async reset and a full netlist loop.
`timescale 1ns/1ps
module tb_bist_stim_compactor;

   localparam int          PAT_A  = 2;
   localparam int          SET_A  = 0;
   localparam int          PAT_B  = 4095;
   localparam int          SET_B  = 1;
   localparam logic [11:0] SEED_V = 12'h001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, abort_a, busy_a, done_a, pass_a;
   logic [7:0]  gold_a, po_a, sig_a;
   logic [11:0] pi_a, idx_a;
   logic        start_b, abort_b, busy_b, done_b, pass_b;
   logic [7:0]  gold_b, po_b, sig_b, po_b_const;
   logic [11:0] pi_b, idx_b;
   logic        net_mode;

   int n_cmp = 0;
   int n_bad = 0;

   // Stand-in combinational benchmark netlist: 12 PIs -> 8 POs
   function automatic logic [7:0] netlist(input logic [11:0] p);
      return (p[11:4] ^ p[7:0]) + {p[3:0], p[11:8]};
   endfunction

   function automatic logic [7:0] model_sig(input int n, input logic [11:0] seed);
      logic [11:0] l;
      logic [7:0]  m;
      l = seed;
      m = 8'h00;
      for (int i = 0; i < n; i++) begin
         m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ netlist(l);
         l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
      end
      return m;
   endfunction

   always_comb po_b = net_mode ? netlist(pi_b) : po_b_const;

   bist_stim_compactor #(.PAT_CNT(PAT_A), .SETTLE_CYC(SET_A), .SEED(SEED_V)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .golden_sig(gold_a),
      .po_in(po_a), .pi_out(pi_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .signature(sig_a), .pat_idx(idx_a)
   );

   bist_stim_compactor #(.PAT_CNT(PAT_B), .SETTLE_CYC(SET_B), .SEED(SEED_V)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .golden_sig(gold_b),
      .po_in(po_b), .pi_out(pi_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .signature(sig_b), .pat_idx(idx_b)
   );

   initial begin
      assert (PAT_A >= 1 && PAT_A <= 4095) else $error("PAT_A out of legal range");
      assert (PAT_B >= 1 && PAT_B <= 4095) else $error("PAT_B out of legal range");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0] po;
      logic [7:0] gold;
      logic [7:0] sig1;
      logic [7:0] sig2;
      logic       pass;
   } vec_t;

   vec_t        vecs [7];
   logic [11:0] lfsr_exp [10];
   bit          seen [4096];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          ndist;
      int          ndup;
      int          k;
      logic [11:0] prev;
      logic [11:0] held_pi;

      vecs[0] = '{8'h01, 8'h03, 8'h01, 8'h03, 1'b1};
      vecs[1] = '{8'h01, 8'h02, 8'h01, 8'h03, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{8'hFF, 8'h01, 8'hFF, 8'h01, 1'b1};
      vecs[4] = '{8'h80, 8'h81, 8'h80, 8'h81, 1'b1};
      vecs[5] = '{8'h80, 8'h00, 8'h80, 8'h81, 1'b0};
      vecs[6] = '{8'h5A, 8'hEE, 8'h5A, 8'hEE, 1'b1};
      lfsr_exp = '{12'h001, 12'h001, 12'h003, 12'h003, 12'h007,
                   12'h007, 12'h00F, 12'h00F, 12'h01E, 12'h01E};

      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; gold_a = 8'h00; po_a = 8'h00;
      start_b = 1'b0; abort_b = 1'b0; gold_b = 8'h00; po_b_const = 8'h00;
      net_mode = 1'b0;
      #12;
      rst_n = 1'b1;
      tick();

      chk("rst_pi_a", 32'(pi_a), 32'h0);
      chk("rst_sig_a", 32'(sig_a), 32'h0);
      chk("rst_idx_a", 32'(idx_a), 32'h0);
      chk("rst_flags_a", {29'd0, busy_a, done_a, pass_a}, 32'h0);
      chk("rst_pi_b", 32'(pi_b), 32'h0);
      chk("rst_flags_b", {29'd0, busy_b, done_b, pass_b}, 32'h0);

      // Table-driven two-pattern runs with constant response
      for (int i = 0; i < 7; i++) begin
         po_a   = vecs[i].po;
         gold_a = vecs[i].gold;
         start_a = 1'b1;
         tick();
         start_a = 1'b0;
         chk("a_busy_seed", {30'd0, busy_a, done_a}, 32'h2);
         tick();
         tick();
         chk("a_sig1", 32'(sig_a), 32'(vecs[i].sig1));
         chk("a_idx1", 32'(idx_a), 32'd1);
         tick();
         chk("a_done_lat3", {30'd0, busy_a, done_a}, 32'h1);
         chk("a_sig2", 32'(sig_a), 32'(vecs[i].sig2));
         chk("a_pass", 32'(pass_a), 32'(vecs[i].pass));
         chk("a_idx2", 32'(idx_a), 32'd2);
         tick();
         tick();
         chk("a_done_held", {30'd0, done_a, pass_a}, {30'd0, 1'b1, vecs[i].pass});
         $display("vec %0d: po=%h golden=%h sig=%h pass=%b", i, po_a, gold_a, sig_a, pass_a);
      end

      // LFSR order, each value held SETTLE_CYC+1 = 2 cycles
      po_b_const = 8'h00;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("b_lfsr_order", 32'(pi_b), 32'(lfsr_exp[i]));
      end
      chk("b_idx_after_order", 32'(idx_b), 32'd4);
      $display("lfsr order: pi_out=%h pat_idx=%0d", pi_b, idx_b);

      // Abort at pat_idx 10
      k = 0;
      while (idx_b != 12'd10 && k < 100) begin
         tick();
         k++;
      end
      chk("b_reach_idx10", 32'(idx_b), 32'd10);
      abort_b = 1'b1;
      start_b = 1'b1;
      tick();
      abort_b = 1'b0;
      start_b = 1'b0;
      chk("b_abort_flags", {30'd0, busy_b, done_b}, 32'h0);
      chk("b_abort_idx_kept", 32'(idx_b), 32'd10);
      held_pi = pi_b;
      tick(); tick(); tick();
      chk("b_idle_pi_stable", 32'(pi_b), 32'(held_pi));
      chk("b_idle_busy", 32'(busy_b), 32'h0);
      $display("abort: pat_idx=%0d pi_out=%h busy=%b", idx_b, pi_b, busy_b);

      // Fresh start reseeds, then async reset during CAPTURE
      po_b_const = 8'hA5;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      tick();
      chk("b_reseed_idx", 32'(idx_b), 32'd0);
      chk("b_reseed_pi", 32'(pi_b), 32'h001);
      chk("b_reseed_sig", 32'(sig_b), 32'h0);
      tick(); tick(); tick();
      chk("b_precap_sig", 32'(sig_b), 32'hA5);
      chk("b_precap_idx", 32'(idx_b), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("b_arst_pi", 32'(pi_b), 32'h0);
      chk("b_arst_sig", 32'(sig_b), 32'h0);
      chk("b_arst_idx", 32'(idx_b), 32'h0);
      chk("b_arst_flags", {29'd0, busy_b, done_b, pass_b}, 32'h0);
      #1;
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("b_post_rst_quiet", {pi_b, sig_b, idx_b, busy_b}, 33'h0);
      $display("async reset: pi_out=%h sig=%h pat_idx=%0d", pi_b, sig_b, idx_b);

      // Full-period run with the netlist in the loop
      net_mode = 1'b1;
      gold_b = model_sig(PAT_B, SEED_V);
      for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
      ndist = 0;
      ndup  = 0;
      prev  = pi_b;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      cyc = 0;
      while (!done_b && cyc < 9000) begin
         start_b = (cyc == 50);
         tick();
         cyc++;
         if (busy_b && pi_b != prev) begin
            if (seen[pi_b]) ndup++;
            else begin
               seen[pi_b] = 1'b1;
               ndist++;
            end
         end
         prev = pi_b;
         if (cyc == 51) begin
            chk("b_start_ignored", {19'd0, busy_b, idx_b}, {19'd0, 1'b1, 12'd25});
         end
      end
      start_b = 1'b0;
      chk("b_run_done", 32'(done_b), 32'h1);
      chk("b_run_cycles", 32'(cyc), 32'(1 + PAT_B * (SET_B + 1)));
      chk("b_run_idx", 32'(idx_b), 32'd4095);
      chk("b_run_sig", 32'(sig_b), 32'(gold_b));
      chk("b_run_pass", 32'(pass_b), 32'h1);
      chk("b_run_distinct", 32'(ndist), 32'd4095);
      chk("b_run_dup", 32'(ndup), 32'd0);
      chk("b_run_nozero", 32'(seen[0]), 32'h0);
      $display("netlist run: cycles=%0d pat_idx=%0d sig=%h golden=%h pass=%b distinct=%0d",
               cyc, idx_b, sig_b, gold_b, pass_b, ndist);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
